proc_scheduler: RTL and testbench

//  Parametrised round-robin process scheduler; successor to the fixed two-context PC controller.

---
 rtl/proc_scheduler_if.sv | 28 ++
 rtl/proc_scheduler.sv | 107 ++++++++++
 tb/tb_proc_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/proc_scheduler_if.sv
// proc_scheduler_if: ControlUnit/ProgramCounter-facing signals of proc_scheduler.
interface proc_scheduler_if #(
  parameter int NUM_PROCS = 4,
  parameter int PC_WIDTH  = 32
);
  localparam int IW = $clog2(NUM_PROCS);
  logic                 halt_i;
  logic [PC_WIDTH-1:0]  pc_curr_i;
  logic                 start_i;
  logic [IW-1:0]        start_id_i;
  logic [PC_WIDTH-1:0]  start_pc_i;
  logic                 yield_i;
  logic                 end_proc_i;
  logic [PC_WIDTH-1:0]  pc_new_o;
  logic                 pc_load_o;
  logic [IW-1:0]        curr_proc_o;
  logic                 enable_so_o;
  logic                 switch_busy_o;
  logic [NUM_PROCS-1:0] active_mask_o;
  modport slave (
    input  halt_i, pc_curr_i, start_i, start_id_i, start_pc_i, yield_i, end_proc_i,
    output pc_new_o, pc_load_o, curr_proc_o, enable_so_o, switch_busy_o, active_mask_o
  );
  modport master (
    output halt_i, pc_curr_i, start_i, start_id_i, start_pc_i, yield_i, end_proc_i,
    input  pc_new_o, pc_load_o, curr_proc_o, enable_so_o, switch_busy_o, active_mask_o
  );
endinterface

// File: rtl/proc_scheduler.sv
// proc_scheduler: round-robin scheduler over NUM_PROCS saved-PC slots.
// Define SCHED_PREEMPT_EN for quantum-based preemption; otherwise cooperative only.
module proc_scheduler #(
  parameter int                  NUM_PROCS = 4,
  parameter int                  PC_WIDTH  = 32,
  parameter int                  QUANTUM   = 16,
  parameter logic [PC_WIDTH-1:0] KERNEL_PC = '0
) (
  input logic             clk_i,
  input logic             rst_i,
  proc_scheduler_if.slave sch
);
  localparam int IW = $clog2(NUM_PROCS);
  typedef enum logic [2:0] {IDLE, RUN, SAVE, SELECT, RESTORE} state_e;
  state_e               state_q;
  logic [PC_WIDTH-1:0]  saved_q [NUM_PROCS];
  logic [NUM_PROCS-1:0] active_q, active_d;
  logic [IW-1:0]        curr_q, next_slot, j;
  logic [PC_WIDTH-1:0]  pc_new_q;
  logic                 pc_load_q, enable_so_q, start_ok, end_ok;
`ifdef SCHED_PREEMPT_EN
  localparam int CW = $clog2(QUANTUM);
  logic [CW-1:0] count_q;
`else
  logic unused_ok;
  assign unused_ok = ^{sch.halt_i, QUANTUM};
`endif
  // the running slot cannot be reloaded underneath itself
  assign start_ok = sch.start_i && !(state_q == RUN && sch.start_id_i == curr_q);
  assign end_ok   = state_q == RUN && sch.end_proc_i;
  always_comb begin
    active_d = active_q;
    if (start_ok) active_d[sch.start_id_i] = 1'b1;
    if (end_ok) active_d[curr_q] = 1'b0;
  end
  // descending scan so the nearest successor of curr_q wins; curr_q itself is last
  always_comb begin
    next_slot = curr_q;
    j = '0;
    for (int i = NUM_PROCS; i >= 1; i--) begin
      j = IW'((32'(curr_q) + i) % NUM_PROCS);
      if (active_q[j]) next_slot = j;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      active_q    <= '0;
      curr_q      <= '0;
      pc_new_q    <= KERNEL_PC;
      pc_load_q   <= 1'b0;
      enable_so_q <= 1'b1;
      for (int i = 0; i < NUM_PROCS; i++) saved_q[i] <= '0;
`ifdef SCHED_PREEMPT_EN
      count_q     <= '0;
`endif
    end else begin
      active_q  <= active_d;
      pc_load_q <= 1'b0;
      if (start_ok) saved_q[sch.start_id_i] <= sch.start_pc_i;
      case (state_q)
        IDLE: if (|active_q) state_q <= SELECT;
        RUN: begin
`ifdef SCHED_PREEMPT_EN
          if (!sch.halt_i) count_q <= count_q + 1'b1;
`endif
          if (sch.end_proc_i) state_q <= SELECT;
          else if (sch.yield_i) begin
            saved_q[curr_q] <= sch.pc_curr_i + 1'b1;
            state_q         <= SAVE;
          end
`ifdef SCHED_PREEMPT_EN
          else if (!sch.halt_i && count_q == CW'(QUANTUM - 1)) begin
            saved_q[curr_q] <= sch.pc_curr_i;
            state_q         <= SAVE;
          end
`endif
        end
        SAVE: state_q <= SELECT;
        SELECT: begin
          pc_load_q <= 1'b1;
          if (|active_q) begin
            state_q     <= RESTORE;
            pc_new_q    <= saved_q[next_slot];
            curr_q      <= next_slot;
            enable_so_q <= 1'b0;
`ifdef SCHED_PREEMPT_EN
            count_q     <= '0;
`endif
          end else begin
            state_q     <= IDLE;
            pc_new_q    <= KERNEL_PC;
            enable_so_q <= 1'b1;
          end
        end
        RESTORE: state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sch.pc_new_o      = pc_new_q;
  assign sch.pc_load_o     = pc_load_q;
  assign sch.curr_proc_o   = curr_q;
  assign sch.enable_so_o   = enable_so_q;
  assign sch.switch_busy_o = state_q inside {SAVE, SELECT, RESTORE};
  assign sch.active_mask_o = active_q;
endmodule

// File: tb/tb_proc_scheduler.sv
// tb_proc_scheduler: directed scenarios plus random traffic against a timeline model of the scheduler.
module tb_proc_scheduler;
  localparam int N = 4, PW = 32, Q = 8;
  localparam logic [31:0] KPC = 32'h100;
  logic clk = 0, rst = 1;
  proc_scheduler_if #(.NUM_PROCS(N), .PC_WIDTH(PW)) sif ();
  proc_scheduler #(.NUM_PROCS(N), .PC_WIDTH(PW), .QUANTUM(Q), .KERNEL_PC(KPC)) dut (
    .clk_i(clk), .rst_i(rst), .sch(sif.slave)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  bit act [N];
  logic [31:0] sav [N];
  int cur, cyc, sel_cyc, run_from, used;
  bit running, idle, ld, en, busy;
  logic [31:0] epc;
  function automatic int pick();
    for (int k = 1; k <= N; k++) if (act[(cur + k) % N]) return (cur + k) % N;
    return -1;
  endfunction
  function automatic bit any_act();
    for (int i = 0; i < N; i++) if (act[i]) return 1;
    return 0;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin act[i] = 0; sav[i] = 0; end
    cur = 0; cyc = 0; sel_cyc = -1; run_from = 0; used = 0;
    running = 0; idle = 1; ld = 0; en = 1; busy = 0; epc = KPC;
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_pc_load"}, sif.pc_load_o, 0);
    check({tag, "_enable_so"}, sif.enable_so_o, 1);
    check({tag, "_mask"}, sif.active_mask_o, 0);
    check({tag, "_pc_new"}, sif.pc_new_o, KPC);
    check({tag, "_curr"}, sif.curr_proc_o, 0);
    check({tag, "_busy"}, sif.switch_busy_o, 0);
  endtask
  // One clock: drive inputs, advance the model across the edge, compare at the next negedge.
  // A selection happens one cycle after end_proc, two after yield/expiry, one after an idle cycle sees work.
  task automatic tick(input bit st, input int sid, input logic [31:0] spc,
                      input bit y, input bit e, input bit h, input logic [31:0] pcc);
    bit in_run;
    int n;
    logic [N-1:0] m;
    sif.start_i = st; sif.start_id_i = 2'(sid); sif.start_pc_i = spc;
    sif.yield_i = y; sif.end_proc_i = e; sif.halt_i = h; sif.pc_curr_i = pcc;
    in_run = running && cyc >= run_from;
    ld = 0;
    if (cyc == sel_cyc) begin
      sel_cyc = -1;
      n = pick();
      ld = 1;
      if (n >= 0) begin
        cur = n; epc = sav[n]; en = 0; running = 1; run_from = cyc + 2; used = 0; idle = 0;
      end else begin
        epc = KPC; en = 1; idle = 1;
      end
    end else if (idle && any_act()) sel_cyc = cyc + 1;
    if (in_run) begin
      if (e) begin act[cur] = 0; sel_cyc = cyc + 1; running = 0; end
      else if (y) begin sav[cur] = pcc + 1; sel_cyc = cyc + 2; running = 0; end
`ifdef SCHED_PREEMPT_EN
      else if (!h) begin
        used++;
        if (used == Q) begin sav[cur] = pcc; sel_cyc = cyc + 2; running = 0; end
      end
`endif
    end
    if (st && !(in_run && sid == cur)) begin act[sid] = 1; sav[sid] = spc; end
    busy = sel_cyc > cyc || (ld && running);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < N; i++) m[i] = act[i];
    check("pc_load", sif.pc_load_o, ld);
    check("pc_new", sif.pc_new_o, epc);
    check("curr_proc", sif.curr_proc_o, cur);
    check("enable_so", sif.enable_so_o, en);
    check("switch_busy", sif.switch_busy_o, busy);
    check("active_mask", sif.active_mask_o, m);
  endtask
  task automatic idle_tick();
    tick(0, 0, 0, 0, 0, 0, $urandom);
  endtask
  task automatic wait_run();
    for (int k = 0; k < 20 && !(running && cyc >= run_from); k++) idle_tick();
    check("wait_run_timeout", running && cyc >= run_from, 1);
  endtask
  task automatic do_reset(input string tag);
    rst = 1;
    #2;
    check_reset(tag);
    rst = 0;
    model_reset();
  endtask
  int lat;
  initial begin
    sif.start_i = 0; sif.start_id_i = 0; sif.start_pc_i = 0; sif.yield_i = 0;
    sif.end_proc_i = 0; sif.halt_i = 0; sif.pc_curr_i = 0;
    model_reset();
    @(negedge clk);
    check_reset("rst");
    @(negedge clk);
    rst = 0;
    idle_tick();
    tick(1, 1, 32'h40, 0, 0, 0, 0);
    wait_run();
    tick(1, 3, 32'h80, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 32'h45);
    wait_run();
    check("yield_to_slot3", sif.pc_new_o, 32'h80);
    tick(0, 0, 0, 1, 0, 0, 32'h85);
    wait_run();
    check("yield_restore_slot1", sif.pc_new_o, 32'h46);
    tick(0, 0, 0, 1, 1, 0, 32'h50);
    idle_tick();
    check("end_wins_load_t2", sif.pc_load_o, 1);
    wait_run();
    tick(0, 0, 0, 0, 1, 0, 32'h90);
    idle_tick();
    check("end_last_kernel", sif.pc_new_o, KPC);
    repeat (3) idle_tick();
    tick(1, 0, 32'h10, 0, 0, 0, 0);
    tick(1, 2, 32'h20, 0, 0, 0, 0);
    wait_run();
`ifdef SCHED_PREEMPT_EN
    lat = 0;
    for (int k = 0; k < 40 && sif.pc_load_o !== 1'b1; k++) begin idle_tick(); lat++; end
    check("quantum_latency", lat, Q + 2);
    wait_run();
    lat = 0;
    for (int k = 0; k < 40 && sif.pc_load_o !== 1'b1; k++) begin
      tick(0, 0, 0, 0, 0, k < 5, $urandom);
      lat++;
    end
    check("quantum_latency_halt", lat, Q + 7);
    wait_run();
`else
    tick(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    wait_run();
`endif
    tick(0, 0, 0, 1, 0, 0, 32'h1234);
    for (int k = 0; k < 10 && !(ld && running); k++) idle_tick();
    check("restore_reached", sif.pc_load_o, 1);
    do_reset("rst_mid_restore");
    idle_tick();
    for (int k = 0; k < 1500; k++)
      tick($urandom_range(0, 7) == 0, $urandom_range(0, N - 1), $urandom,
           $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0,
           ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
